// File: rtl/glip_jtag_rx_deserializer_pkg.sv
// glip_jtag_rx_deserializer_pkg: shared state encoding and default widths for the JTAG ingress deserializer
package glip_jtag_rx_deserializer_pkg;
  localparam int WORD_WIDTH_DEF = 34;
  localparam int FREE_SPACE_WIDTH_DEF = 5;
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;
endpackage

// File: rtl/glip_jtag_rx_deserializer_if.sv
// glip_jtag_rx_deserializer_if: valid/ready flit push channel into the ingress FIFO
interface glip_jtag_rx_deserializer_if #(
  parameter int WORD_WIDTH = 34
) ();
  logic [WORD_WIDTH-1:0] flit;
  logic                  valid;
  logic                  ready;
  modport master (output flit, output valid, input ready);
  modport slave  (input flit, input valid, output ready);
endinterface

// File: rtl/glip_jtag_rx_deserializer_credit.sv
// glip_jtag_credit_shifter: computes FIFO credit at DR capture and shifts it out LSB first on a registered tdo
module glip_jtag_credit_shifter
  import glip_jtag_rx_deserializer_pkg::*;
#(
  parameter int FREE_SPACE_WIDTH = FREE_SPACE_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        capture,
  input  logic                        shift,
  input  logic [FREE_SPACE_WIDTH-1:0] free_space,
  input  logic                        held,
  output logic                        tdo
);
  logic [FREE_SPACE_WIDTH-1:0] credit, credit_sr_q, credit_sr_d;
  logic                        tdo_q, tdo_d;
  // a word already waiting in the holding register consumes one FIFO slot
  always_comb begin
    credit = (held && free_space == '0) ? '0 : free_space - {{(FREE_SPACE_WIDTH-1){1'b0}}, held};
    credit_sr_d = capture ? credit : shift ? credit_sr_q >> 1 : credit_sr_q;
    tdo_d = shift ? credit_sr_q[0] : tdo_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_sr_q <= '0;
      tdo_q <= 1'b0;
    end else begin
      credit_sr_q <= credit_sr_d;
      tdo_q <= tdo_d;
    end
  end
  assign tdo = tdo_q;
endmodule

// File: rtl/glip_jtag_rx_deserializer.sv
// glip_jtag_rx_deserializer: assembles the TDI bit stream into flits and pushes them to the ingress FIFO
module glip_jtag_rx_deserializer
  import glip_jtag_rx_deserializer_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int FREE_SPACE_WIDTH = FREE_SPACE_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              dr_capture,
  input  logic                              dr_shift,
  input  logic                              dr_update,
  input  logic                              tdi,
  output logic                              tdo,
  glip_jtag_rx_deserializer_if.master       out,
  input  logic [FREE_SPACE_WIDTH-1:0]       fifo_free_space,
  output logic                              overflow_err
);
  localparam int CW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [WORD_WIDTH-1:0] word_sr_q, word_sr_d, out_flit_q, out_flit_d, new_word;
  logic                  out_valid_q, out_valid_d, overflow_q, overflow_d;
  logic                  upd, sh, last, complete, pop;
  // event priority: capture beats update beats shift; shifts only count inside a scan
  always_comb begin
    upd = dr_update & ~dr_capture;
    sh = dr_shift & ~dr_capture & ~dr_update & (state_q == ST_SCAN);
    last = bit_cnt_q == CW'(WORD_WIDTH - 1);
    complete = sh & last;
    pop = out_valid_q & out.ready;
    new_word = {tdi, word_sr_q[WORD_WIDTH-1:1]};
    state_d = dr_capture ? ST_SCAN : (upd ? ST_IDLE : state_q);
    bit_cnt_d = (dr_capture | upd) ? '0 : sh ? (last ? '0 : bit_cnt_q + 1'b1) : bit_cnt_q;
    word_sr_d = sh ? new_word : word_sr_q;
    out_flit_d = (complete && (!out_valid_q || pop)) ? new_word : out_flit_q;
    out_valid_d = complete ? 1'b1 : out_valid_q & ~out.ready;
    overflow_d = overflow_q | (complete & out_valid_q & ~out.ready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bit_cnt_q <= '0;
      word_sr_q <= '0;
      out_flit_q <= '0;
      out_valid_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_cnt_q <= bit_cnt_d;
      word_sr_q <= word_sr_d;
      out_flit_q <= out_flit_d;
      out_valid_q <= out_valid_d;
      overflow_q <= overflow_d;
    end
  end
  glip_jtag_credit_shifter #(.FREE_SPACE_WIDTH(FREE_SPACE_WIDTH)) u_credit (
    .clk(clk),
    .rst(rst),
    .capture(dr_capture),
    .shift(sh),
    .free_space(fifo_free_space),
    .held(out_valid_q),
    .tdo(tdo)
  );
  assign out.flit = out_flit_q;
  assign out.valid = out_valid_q;
  assign overflow_err = overflow_q;
endmodule

// File: tb/tb_glip_jtag_rx_deserializer.sv
// tb_glip_jtag_rx_deserializer: directed scenario bench for the JTAG ingress deserializer (16-bit words)
module tb_glip_jtag_rx_deserializer;
  localparam int W = 16;
  localparam int FSW = 5;
  logic clk = 1'b0, rst = 1'b1;
  logic dr_capture = 1'b0, dr_shift = 1'b0, dr_update = 1'b0, tdi = 1'b0;
  logic tdo, overflow_err;
  logic [FSW-1:0] fifo_free_space = '0;
  int total = 0, bad = 0;
  logic tdo_log [0:W-1];
  logic [W-1:0] pops [$];
  glip_jtag_rx_deserializer_if #(.WORD_WIDTH(W)) ff ();
  glip_jtag_rx_deserializer #(.WORD_WIDTH(W), .FREE_SPACE_WIDTH(FSW)) dut (
    .clk(clk), .rst(rst), .dr_capture(dr_capture), .dr_shift(dr_shift), .dr_update(dr_update),
    .tdi(tdi), .tdo(tdo), .out(ff.master), .fifo_free_space(fifo_free_space), .overflow_err(overflow_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (ff.valid && ff.ready) pops.push_back(ff.flit);
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic capture(input logic [FSW-1:0] fs);
    fifo_free_space = fs;
    dr_capture = 1'b1;
    tick();
    dr_capture = 1'b0;
  endtask
  task automatic update();
    dr_update = 1'b1;
    tick();
    dr_update = 1'b0;
  endtask
  task automatic shift_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      dr_shift = 1'b1;
      tdi = w[i];
      tick();
      tdo_log[i] = tdo;
    end
    dr_shift = 1'b0;
    tdi = 1'b0;
  endtask
  task automatic test_reset();
    ff.ready = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
    total++; if (ff.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ff.valid); end
    total++; if (ff.flit !== 16'h0) begin bad++; $display("FAIL reset_flit got=%h exp=0000", ff.flit); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", overflow_err); end
  endtask
  task automatic test_single_word();
    logic [4:0] exp_tdo = 5'b10000;
    ff.ready = 1'b1;
    pops.delete();
    capture(5'd16);
    shift_bits(16'hA5C3, 16);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (tdo_log[i] !== exp_tdo[i]) begin bad++; $display("FAIL single_tdo[%0d] got=%b exp=%b", i, tdo_log[i], exp_tdo[i]); end
    end
    total++; if (ff.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", ff.valid); end
    total++; if (ff.flit !== 16'hA5C3) begin bad++; $display("FAIL single_flit got=%h exp=a5c3", ff.flit); end
    tick();
    total++; if (ff.valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%b exp=0", ff.valid); end
    total++; if (pops.size() !== 1) begin bad++; $display("FAIL single_pops got=%0d exp=1", pops.size()); end
  endtask
  task automatic test_back_to_back();
    pops.delete();
    shift_bits(16'h0001, 16);
    shift_bits(16'hFFFF, 16);
    tick();
    total++; if (pops.size() !== 2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", pops.size()); end
    if (pops.size() == 2) begin
      total++; if (pops[0] !== 16'h0001) begin bad++; $display("FAIL b2b_first got=%h exp=0001", pops[0]); end
      total++; if (pops[1] !== 16'hFFFF) begin bad++; $display("FAIL b2b_second got=%h exp=ffff", pops[1]); end
    end
  endtask
  task automatic test_overflow();
    ff.ready = 1'b0;
    update();
    capture(5'd16);
    shift_bits(16'h1234, 16);
    total++; if (ff.flit !== 16'h1234 || ff.valid !== 1'b1) begin bad++; $display("FAIL ovf_first got=%h/%b exp=1234/1", ff.flit, ff.valid); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", overflow_err); end
    shift_bits(16'h5678, 16);
    total++; if (ff.flit !== 16'h1234) begin bad++; $display("FAIL ovf_kept got=%h exp=1234", ff.flit); end
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
    ff.ready = 1'b1;
    tick(); tick();
    total++; if (overflow_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
    total++; if (ff.valid !== 1'b0) begin bad++; $display("FAIL ovf_drain got=%b exp=0", ff.valid); end
  endtask
  task automatic test_partial_discard();
    rst = 1'b1; tick(); rst = 1'b0;
    pops.delete();
    capture(5'd16);
    shift_bits(16'h007F, 7);
    update();
    tick();
    total++; if (pops.size() !== 0 || ff.valid !== 1'b0) begin bad++; $display("FAIL partial_push got=%0d exp=0", pops.size()); end
    capture(5'd16);
    shift_bits(16'hBEEF, 16);
    total++; if (ff.flit !== 16'hBEEF || ff.valid !== 1'b1) begin bad++; $display("FAIL partial_next got=%h/%b exp=beef/1", ff.flit, ff.valid); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL partial_ovf got=%b exp=0", overflow_err); end
    tick();
  endtask
  task automatic test_credit_saturation();
    logic [4:0] exp_two = 5'b00010;
    ff.ready = 1'b0;
    update();
    capture(5'd16);
    shift_bits(16'h0F0F, 16);
    update();
    capture(5'd3);
    shift_bits(16'h0000, 5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (tdo_log[i] !== exp_two[i]) begin bad++; $display("FAIL credit3_tdo[%0d] got=%b exp=%b", i, tdo_log[i], exp_two[i]); end
    end
    update();
    capture(5'd0);
    shift_bits(16'h0000, 5);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (tdo_log[i] !== 1'b0) begin bad++; $display("FAIL credit0_tdo[%0d] got=%b exp=0", i, tdo_log[i]); end
    end
    total++; if (ff.flit !== 16'h0F0F || ff.valid !== 1'b1) begin bad++; $display("FAIL credit_hold got=%h/%b exp=0f0f/1", ff.flit, ff.valid); end
  endtask
  task automatic test_reset_mid_scan();
    update();
    capture(5'd16);
    shift_bits(16'h01FF, 9);
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if (ff.valid !== 1'b0 || ff.flit !== 16'h0) begin bad++; $display("FAIL midrst_out got=%h/%b exp=0000/0", ff.flit, ff.valid); end
    total++; if (tdo !== 1'b0 || overflow_err !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b/%b exp=0/0", tdo, overflow_err); end
    ff.ready = 1'b1;
    capture(5'd16);
    shift_bits(16'h00FF, 16);
    total++; if (ff.flit !== 16'h00FF || ff.valid !== 1'b1) begin bad++; $display("FAIL midrst_next got=%h/%b exp=00ff/1", ff.flit, ff.valid); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", overflow_err); end
  endtask
  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_partial_discard();
    test_credit_saturation();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
